// File: rtl/game_mechanics_n.sv
// -----------------------------------------------------------------------------
// game_mechanics_n
//
// Game rules engine for a player sprite and NUM_BEES bee sprites. Detects
// player/bee overlap and play-field edge contact, and runs the game FSM
// (IDLE -> PLAY -> HIT (invulnerable) -> PLAY ... -> OVER -> IDLE). Owns lives,
// score and high score, and emits a one-cycle game_reset pulse for the sprite
// control/datapath whenever the game (re)starts or the player is hit.
//
// Optional feature: define EXTRA_LIFE_EN to award a bonus life (capped at
// MAX_LIVES) each time a score increment lands on a nonzero multiple of
// EXTRA_LIFE_PTS. Without the macro, lives only ever decrease.
//
// Ports:
//   clk          in   system clock
//   resetn       in   asynchronous reset, active HIGH despite the name
//   tick         in   one-cycle frame pulse; collision/scoring advance on it
//   start        in   start request, honoured only in IDLE
//   user_x/y     in   player position, COORD_W bits each
//   bee_x/y      in   packed bee positions, bee i at [i*COORD_W +: COORD_W]
//   bee_en       in   per-bee enable
//   game_reset   out  one-cycle pulse on game start / hit / game over
//   game_over    out  high while in OVER
//   lives        out  remaining lives
//   score        out  current score (saturating)
//   high_score   out  best score of completed games
//   hit_mask     out  bees overlapping the player at the last tick
//   state        out  FSM state: IDLE=0, PLAY=1, HIT=2, OVER=3
//
// Handshake: there is no valid/ready pair. tick and start are level inputs
// sampled on each rising clk edge; a one-cycle high on tick is one frame, and
// start is acted upon on any edge where state is IDLE. All outputs are flops.
// -----------------------------------------------------------------------------
module game_mechanics_n #(
  parameter int NUM_BEES        = 4,
  parameter int COORD_W         = 7,
  parameter int SCORE_W         = 8,
  parameter int MAX_LIVES       = 3,
  parameter int HIT_RADIUS      = 3,
  parameter int LEFTEDGE        = 1,
  parameter int RIGHTEDGE       = 124,
  parameter int TOPEDGE         = 1,
  parameter int BOTTOMEDGE      = 116,
  parameter int INVULN_TICKS    = 8,
  parameter int OVER_HOLD_TICKS = 64,
  parameter int EXTRA_LIFE_PTS  = 32,
  localparam int LIVES_W        = $clog2(MAX_LIVES + 1)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          tick,
  input  logic                          start,
  input  logic [COORD_W-1:0]            user_x,
  input  logic [COORD_W-1:0]            user_y,
  input  logic [NUM_BEES*COORD_W-1:0]   bee_x,
  input  logic [NUM_BEES*COORD_W-1:0]   bee_y,
  input  logic [NUM_BEES-1:0]           bee_en,
  output logic                          game_reset,
  output logic                          game_over,
  output logic [LIVES_W-1:0]            lives,
  output logic [SCORE_W-1:0]            score,
  output logic [SCORE_W-1:0]            high_score,
  output logic [NUM_BEES-1:0]           hit_mask,
  output logic [1:0]                    state
);

  // Coordinates are compared as signed values one bit wider than COORD_W so
  // that the difference never wraps around the play field.
  localparam int DW = COORD_W + 1;
  localparam int CNT_MAX = (INVULN_TICKS > OVER_HOLD_TICKS) ? INVULN_TICKS : OVER_HOLD_TICKS;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [DW-1:0]      RADIUS    = DW'(HIT_RADIUS);
  localparam logic [COORD_W-1:0] LEFT_C    = COORD_W'(LEFTEDGE);
  localparam logic [COORD_W-1:0] RIGHT_C   = COORD_W'(RIGHTEDGE);
  localparam logic [COORD_W-1:0] TOP_C     = COORD_W'(TOPEDGE);
  localparam logic [COORD_W-1:0] BOTTOM_C  = COORD_W'(BOTTOMEDGE);
  localparam logic [LIVES_W-1:0] LIVES_MAX = LIVES_W'(MAX_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE = LIVES_W'(1);
  localparam logic [CNT_W-1:0]   INV_C     = CNT_W'(INVULN_TICKS);
  localparam logic [CNT_W-1:0]   OVER_C    = CNT_W'(OVER_HOLD_TICKS);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] EXTRA_PTS = SCORE_W'(EXTRA_LIFE_PTS);

`ifdef EXTRA_LIFE_EN
  localparam bit EXTRA_ON = 1'b1;
`else
  localparam bit EXTRA_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   high_q, high_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_BEES-1:0]  hit_mask_q, hit_mask_d;
  logic                 game_reset_q, game_reset_d;
  logic                 game_over_q, game_over_d;

  logic [NUM_BEES-1:0]  bee_hits;
  logic                 edge_hit;
  logic                 collided;
  logic [SCORE_W-1:0]   score_inc;
  logic [LIVES_W-1:0]   lives_bonus;
  logic                 score_sat;
  logic                 bonus;
  logic                 pulse_req;

  // |a - b| computed on zero-extended signed operands.
  function automatic logic [DW-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                             input logic [COORD_W-1:0] b);
    logic signed [DW-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[DW-1] ? DW'(-d) : DW'(d);
  endfunction

  // ---------------------------------------------------------------------------
  // Collision detection
  // ---------------------------------------------------------------------------
  always_comb begin : collision_comb
    bee_hits = '0;
    for (int i = 0; i < NUM_BEES; i++) begin
      bee_hits[i] = bee_en[i]
                  && (abs_diff(user_x, bee_x[i*COORD_W +: COORD_W]) <= RADIUS)
                  && (abs_diff(user_y, bee_y[i*COORD_W +: COORD_W]) <= RADIUS);
    end
    edge_hit = (user_x <= LEFT_C) || (user_x >= RIGHT_C)
            || (user_y <= TOP_C)  || (user_y >= BOTTOM_C);
    collided = edge_hit || (|bee_hits);
  end

  // ---------------------------------------------------------------------------
  // Score increment with saturation, and the optional bonus life it may earn
  // ---------------------------------------------------------------------------
  always_comb begin : score_comb
    score_sat   = (score_q == SCORE_MAX);
    score_inc   = score_sat ? score_q : score_q + SCORE_W'(1);
    // A saturated score does not increment, so it can never earn a bonus.
    bonus       = EXTRA_ON && !score_sat && ((score_inc % EXTRA_PTS) == '0);
    lives_bonus = (bonus && (lives_q < LIVES_MAX)) ? lives_q + LIVES_ONE : lives_q;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge resetn) begin : state_reg
    if (resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin : next_state_comb
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_PLAY;
      S_PLAY: if (tick && collided) state_d = (lives_q > LIVES_ONE) ? S_HIT : S_OVER;
      S_HIT:  if (tick && (cnt_q == CNT_ONE)) state_d = S_PLAY;
      S_OVER: if (tick && (cnt_q == CNT_ONE)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin : output_comb
    lives_d     = lives_q;
    score_d     = score_q;
    high_d      = high_q;
    cnt_d       = cnt_q;
    game_over_d = game_over_q;
    hit_mask_d  = tick ? bee_hits : hit_mask_q;
    pulse_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lives_d     = LIVES_MAX;
          score_d     = '0;
          game_over_d = 1'b0;
          pulse_req   = 1'b1;
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (collided) begin
            // Edge and bee contact on one tick still cost a single life.
            pulse_req = 1'b1;
            if (lives_q > LIVES_ONE) begin
              lives_d = lives_q - LIVES_ONE;
              cnt_d   = INV_C;
            end else begin
              lives_d     = '0;
              cnt_d       = OVER_C;
              game_over_d = 1'b1;
              if (score_q > high_q) high_d = score_q;
            end
          end else begin
            score_d = score_inc;
            lives_d = lives_bonus;
          end
        end
      end
      S_HIT: begin
        if (tick) begin
          score_d = score_inc;
          lives_d = lives_bonus;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_OVER: begin
        if (tick) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) game_over_d = 1'b0;
        end
      end
      default: ;
    endcase
    // Back-to-back requests (e.g. start followed by an immediate hit tick)
    // must not stretch the pulse, so a request right after a pulse is dropped.
    game_reset_d = pulse_req & ~game_reset_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge resetn) begin : data_reg
    if (resetn) begin
      lives_q      <= LIVES_MAX;
      score_q      <= '0;
      high_q       <= '0;
      cnt_q        <= '0;
      hit_mask_q   <= '0;
      game_reset_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      lives_q      <= lives_d;
      score_q      <= score_d;
      high_q       <= high_d;
      cnt_q        <= cnt_d;
      hit_mask_q   <= hit_mask_d;
      game_reset_q <= game_reset_d;
      game_over_q  <= game_over_d;
    end
  end

  assign game_reset = game_reset_q;
  assign game_over  = game_over_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign hit_mask   = hit_mask_q;
  assign state      = state_q;

endmodule

// File: tb/tb_game_mechanics_n.sv
module tb_game_mechanics_n;

  localparam int NB = 4;
  localparam int CW = 7;
  localparam int SW = 8;
  localparam int LW = 2;
  localparam int EW = 2 + LW + SW + SW + 1 + 1 + NB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn = 1'b1;
  logic              tick = 1'b0;
  logic              start = 1'b0;
  logic [CW-1:0]     user_x = '0, user_y = '0;
  logic [NB*CW-1:0]  bee_x = '0, bee_y = '0;
  logic [NB-1:0]     bee_en = '0;
  logic              game_reset, game_over;
  logic [LW-1:0]     lives;
  logic [SW-1:0]     score, high_score;
  logic [NB-1:0]     hit_mask;
  logic [1:0]        state;

  game_mechanics_n dut (
    .clk(clk), .resetn(resetn), .tick(tick), .start(start),
    .user_x(user_x), .user_y(user_y), .bee_x(bee_x), .bee_y(bee_y),
    .bee_en(bee_en), .game_reset(game_reset), .game_over(game_over),
    .lives(lives), .score(score), .high_score(high_score),
    .hit_mask(hit_mask), .state(state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (game rules in plain integers) --------
  // m_st: 0 idle, 1 play, 2 invulnerable, 3 game over
  int m_st, m_lives, m_score, m_hs, m_cnt;
  bit m_gr, m_go;
  logic [NB-1:0] m_hm;
  int ux, uy;
  int bx[NB], by[NB];
  logic [NB-1:0] en;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_lives = 3; m_score = 0; m_hs = 0; m_cnt = 0;
    m_gr = 0; m_go = 0; m_hm = '0;
  endtask

  task automatic add_point();
    if (m_score < 255) begin
      m_score++;
`ifdef EXTRA_LIFE_EN
      if ((m_score % 32) == 0 && m_lives < 3) m_lives++;
`endif
    end
  endtask

  task automatic model_clock(input bit t, input bit s);
    logic [NB-1:0] hits;
    bit at_edge, coll, pulse;
    for (int i = 0; i < NB; i++)
      hits[i] = en[i] && iabs(ux - bx[i]) <= 3 && iabs(uy - by[i]) <= 3;
    at_edge = (ux <= 1) || (ux >= 124) || (uy <= 1) || (uy >= 116);
    coll = at_edge || (hits != 0);
    pulse = 0;
    case (m_st)
      0: if (s) begin m_lives = 3; m_score = 0; m_st = 1; pulse = 1; end
      1: if (t) begin
           if (coll) begin
             pulse = 1;
             if (m_lives > 1) begin m_lives--; m_cnt = 8; m_st = 2; end
             else begin
               m_lives = 0; m_cnt = 64; m_st = 3; m_go = 1;
               if (m_score > m_hs) m_hs = m_score;
             end
           end else add_point();
         end
      2: if (t) begin add_point(); if (m_cnt == 1) m_st = 1; m_cnt--; end
      default: if (t) begin if (m_cnt == 1) begin m_st = 0; m_go = 0; end m_cnt--; end
    endcase
    if (t) m_hm = hits;
    m_gr = pulse && !m_gr;
  endtask

  function automatic logic [EW-1:0] pack_exp();
    return {2'(m_st), LW'(m_lives), SW'(m_score), SW'(m_hs), m_gr, m_go, m_hm};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit t, input bit s);
    bit prev_r;
    @(negedge clk);
    user_x = CW'(ux); user_y = CW'(uy);
    for (int i = 0; i < NB; i++) begin
      bee_x[i*CW +: CW] = CW'(bx[i]);
      bee_y[i*CW +: CW] = CW'(by[i]);
    end
    bee_en = en; tick = t; start = s;
    prev_r = resetn;
    resetn = r;
    if (r) begin
      model_reset();
      if (!prev_r) begin
        // reset must act without waiting for a clock edge
        #1;
        chk("async_state", state, 0);
        chk("async_lives", lives, 3);
        chk("async_score", score, 0);
        chk("async_high", high_score, 0);
        chk("async_game_reset", game_reset, 0);
      end
    end else begin
      model_clock(t, s);
    end
    exp_q.push_back(pack_exp());
    @(posedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic tick_gap();
    step(0, 1, 0);
    idle_cycles($urandom_range(0, 2));
  endtask

  task automatic set_bee(input int i, input int x, input int y, input bit e);
    bx[i] = x; by[i] = y; en[i] = e;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state",      state,      int'(e[EW-1 -: 2]));
      chk("lives",      lives,      int'(e[EW-3 -: LW]));
      chk("score",      score,      int'(e[EW-3-LW -: SW]));
      chk("high_score", high_score, int'(e[EW-3-LW-SW -: SW]));
      chk("game_reset", game_reset, int'(e[NB+1]));
      chk("game_over",  game_over,  int'(e[NB]));
      chk("hit_mask",   hit_mask,   int'(e[NB-1:0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ux = 60; uy = 60; en = '0;
    for (int i = 0; i < NB; i++) begin bx[i] = 0; by[i] = 0; end
    model_reset();

    step(1, 0, 0); step(1, 1, 1); step(1, 0, 0);
    idle_cycles(2);
    step(0, 1, 0);                        // tick in IDLE: ignored except hit_mask
    step(0, 0, 1);                        // start -> PLAY with game_reset pulse
    idle_cycles(2);

    repeat (10) tick_gap();               // safe position, bees off: score 10

    set_bee(2, 62, 57, 1);                // overlap: lives 2, HIT
    tick_gap();
    step(0, 0, 1);                        // start ignored in HIT
    repeat (8) tick_gap();                // invulnerable window then PLAY
    set_bee(2, 0, 0, 0);
    tick_gap();

    set_bee(0, 60, 60, 1);                // second hit: lives 1
    tick_gap();
    repeat (8) tick_gap();
    ux = 124; set_bee(0, 124, 60, 1);     // edge and bee together: one life
    tick_gap();
    step(0, 0, 1);                        // start ignored in OVER
    repeat (64) tick_gap();               // hold then IDLE
    idle_cycles(2);

    // wrap check: bee at far left must not match a player at far right
    en = '0; set_bee(0, 1, 60, 1); ux = 126; uy = 60;
    step(0, 0, 1);
    step(0, 1, 0);
    ux = 60;
    for (int i = 0; i < 300; i++) step(0, 1, 0);  // saturate score
    idle_cycles(2);

    // reset in the middle of the invulnerable window
    set_bee(0, 60, 60, 1);
    tick_gap();
    repeat (3) tick_gap();
    set_bee(0, 1, 60, 1);
    step(1, 1, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // randomized play
    step(0, 0, 1);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        ux = $urandom_range(0, 127);
        uy = $urandom_range(0, 127);
        for (int i = 0; i < NB; i++) begin
          bx[i] = ux + int'($urandom_range(0, 12)) - 6;
          by[i] = uy + int'($urandom_range(0, 12)) - 6;
          if (bx[i] < 0) bx[i] = 0;
          if (bx[i] > 127) bx[i] = 127;
          if (by[i] < 0) by[i] = 0;
          if (by[i] > 127) by[i] = 127;
        end
        en = NB'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0) begin ux = 64; uy = 60; end
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0);
    end

    step(0, 0, 0);
    #3;
    chk("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
